// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b101;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_MEM,
        CLS_BR,
        CLS_J,
        CLS_ILL
    } instr_class_t;

endpackage

// File: rtl/decodificador_aluop.sv
// Combinational opcode decoder: instruction class for DECODE dispatch, and the
// ALU operation plus immediate-extension mode used by EXEC_I.
module decodificador_aluop
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    op_i,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               ext_zero_o,
    output instr_class_t       class_o
);

    always_comb begin
        alu_op_o   = ALUOP_W'(ALU_ADD);
        ext_zero_o = 1'b0;
        class_o    = CLS_ILL;
        case (op_i)
            OP_RTYPE: class_o = CLS_R;
            OP_ADDI:  class_o = CLS_I;
            OP_ANDI: begin
                class_o    = CLS_I;
                alu_op_o   = ALUOP_W'(ALU_AND);
                ext_zero_o = 1'b1;
            end
            OP_ORI: begin
                class_o    = CLS_I;
                alu_op_o   = ALUOP_W'(ALU_OR);
                ext_zero_o = 1'b1;
            end
            OP_SLTI: begin
                class_o  = CLS_I;
                alu_op_o = ALUOP_W'(ALU_SLT);
            end
            OP_LW, OP_SW:   class_o = CLS_MEM;
            OP_BEQ, OP_BNE: class_o = CLS_BR;
            OP_J:           class_o = CLS_J;
            default:        class_o = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS control FSM with memory wait states, bne, zero-extend select,
// optional illegal-opcode trap and a retired-instruction counter.
module unidad_control_multiciclo
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W         = 6,
    parameter int ALUOP_W      = 3,
    parameter int CNT_W        = 32,
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               BranchEq,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic               ExtZero,
    output logic [ALUOP_W-1:0] AluOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired
);

    state_t             state_q, state_d;
    logic               retire_d;
    logic               illegal_q;
    logic [CNT_W-1:0]   retired_q;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_ext_zero;
    instr_class_t       dec_class;

    decodificador_aluop #(
        .OP_W   (OP_W),
        .ALUOP_W(ALUOP_W)
    ) u_dec (
        .op_i      (op),
        .alu_op_o  (dec_aluop),
        .ext_zero_o(dec_ext_zero),
        .class_o   (dec_class)
    );

    // retire_d marks the completing transition back into FETCH
    always_comb begin
        state_d  = state_q;
        retire_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (dec_class)
                    CLS_R:   state_d = S_EXEC_R;
                    CLS_I:   state_d = S_EXEC_I;
                    CLS_MEM: state_d = S_MEM_ADDR;
                    CLS_BR:  state_d = S_BRANCH;
                    CLS_J:   state_d = S_JUMP;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            S_ILLEGAL: state_d = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (TRAP_ILLEGAL && state_d == S_ILLEGAL) illegal_q <= 1'b1;
            if (retire_d) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        BranchEq = 1'b0;
        BranchNe = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemToReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = SRCB_REG;
        ExtZero  = 1'b0;
        AluOp    = '0;
        PCSource = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                AluSrcB = SRCB_FOUR;
                AluOp   = ALUOP_W'(ALU_ADD);
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                AluSrcB = SRCB_IMM_SH;
                AluOp   = ALUOP_W'(ALU_ADD);
            end
            S_MEM_ADDR: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                AluOp   = ALUOP_W'(ALU_ADD);
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_MEM: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                AluSrcA = 1'b1;
                AluOp   = ALUOP_W'(ALU_FUNCT);
            end
            S_EXEC_I: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                AluOp   = dec_aluop;
                ExtZero = dec_ext_zero;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = (op == OP_RTYPE);
            end
            S_BRANCH: begin
                AluSrcA  = 1'b1;
                AluOp    = ALUOP_W'(ALU_SUB);
                PCSource = PCSRC_ALUOUT;
                BranchEq = (op == OP_BEQ);
                BranchNe = (op == OP_BNE);
            end
            S_JUMP: begin
                PCSource = PCSRC_JUMP;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
        // No datapath side effect may escape while reset is held
        if (reset) begin
            PCWrite  = 1'b0;
            BranchEq = 1'b0;
            BranchNe = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign illegal_op = illegal_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for the multicycle control unit: per-cycle control vectors,
// retired counter (including 2-bit wrap) and both illegal-opcode modes.
module tb_unidad_control_multiciclo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       mem_ready = 1'b0;

    logic       pcw_a, beq_a, bne_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, sa_a, ez_a, ill_a;
    logic [1:0] sb_a, pcs_a;
    logic [2:0] aluop_a;
    logic [31:0] ret_a;
    logic       pcw_b, beq_b, bne_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, sa_b, ez_b, ill_b;
    logic [1:0] sb_b, pcs_b;
    logic [2:0] aluop_b;
    logic [1:0] ret_b;

    int n_chk = 0;
    int n_fail = 0;
    int unsigned exp_ret = 0;

    always #5 clk = ~clk;

    unidad_control_multiciclo #(.OP_W(6), .ALUOP_W(3), .CNT_W(32), .TRAP_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(pcw_a), .BranchEq(beq_a), .BranchNe(bne_a), .IorD(iord_a), .MemRead(mr_a),
        .MemWrite(mw_a), .IRWrite(irw_a), .MemToReg(m2r_a), .RegDst(rd_a), .RegWrite(rw_a),
        .AluSrcA(sa_a), .AluSrcB(sb_a), .ExtZero(ez_a), .AluOp(aluop_a), .PCSource(pcs_a),
        .illegal_op(ill_a), .retired(ret_a)
    );

    unidad_control_multiciclo #(.OP_W(6), .ALUOP_W(3), .CNT_W(2), .TRAP_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(pcw_b), .BranchEq(beq_b), .BranchNe(bne_b), .IorD(iord_b), .MemRead(mr_b),
        .MemWrite(mw_b), .IRWrite(irw_b), .MemToReg(m2r_b), .RegDst(rd_b), .RegWrite(rw_b),
        .AluSrcA(sa_b), .AluSrcB(sb_b), .ExtZero(ez_b), .AluOp(aluop_b), .PCSource(pcs_b),
        .illegal_op(ill_b), .retired(ret_b)
    );

    // Field order: PCWrite BranchEq BranchNe IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite AluSrcA AluSrcB ExtZero AluOp PCSource
    wire [18:0] ctl_a = {pcw_a, beq_a, bne_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, sa_a, sb_a, ez_a, aluop_a, pcs_a};
    wire [18:0] ctl_b = {pcw_b, beq_b, bne_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, sa_b, sb_b, ez_b, aluop_b, pcs_b};

    localparam logic [18:0] V_ZERO      = 19'd0;
    localparam logic [18:0] V_FETCH_W   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,3'b110,2'b00};
    localparam logic [18:0] V_FETCH_R   = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,3'b110,2'b00};
    localparam logic [18:0] V_FETCH_RST = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,3'b110,2'b00};
    localparam logic [18:0] V_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,3'b110,2'b00};
    localparam logic [18:0] V_MADDR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,3'b110,2'b00};
    localparam logic [18:0] V_MEMRD     = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00};
    localparam logic [18:0] V_WBMEM     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,3'b000,2'b00};
    localparam logic [18:0] V_MEMWR     = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00};
    localparam logic [18:0] V_MEMWR_RST = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00};
    localparam logic [18:0] V_EXEC_R    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,3'b001,2'b00};
    localparam logic [18:0] V_EXEC_ANDI = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,3'b011,2'b00};
    localparam logic [18:0] V_EXEC_ADDI = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,3'b110,2'b00};
    localparam logic [18:0] V_WB_I      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,3'b000,2'b00};
    localparam logic [18:0] V_WB_R      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,3'b000,2'b00};
    localparam logic [18:0] V_BEQ       = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,3'b101,2'b01};
    localparam logic [18:0] V_BNE       = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,3'b101,2'b01};
    localparam logic [18:0] V_JUMP      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b10};

    // Apply inputs mid-low-phase, then let combinational outputs settle
    task automatic cycle_in(input logic r, input logic mr);
        @(negedge clk);
        reset = r;
        mem_ready = mr;
        #1;
    endtask

    task automatic test_reset();
        cycle_in(1'b1, 1'b1);
        cycle_in(1'b1, 1'b1);
        n_chk++;
        if (ctl_a !== V_FETCH_RST) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected %b", ctl_a, V_FETCH_RST);
        end
        n_chk++;
        if (ret_a !== 32'd0 || ill_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: retired=%0d illegal=%b expected 0/0", ret_a, ill_a);
        end
    endtask

    task automatic test_lw();
        logic        mr_v [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [18:0] ev   [8] = '{V_FETCH_W, V_FETCH_W, V_FETCH_R, V_DECODE, V_MADDR, V_MEMRD, V_MEMRD, V_WBMEM};
        op = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            cycle_in(1'b0, mr_v[i]);
            n_chk++;
            if (ctl_a !== ev[i]) begin
                n_fail++;
                $display("FAIL lw_ctl cycle %0d: got %b expected %b", i, ctl_a, ev[i]);
            end
            n_chk++;
            if (ret_a !== 32'(exp_ret)) begin
                n_fail++;
                $display("FAIL lw_retired cycle %0d: got %0d expected %0d", i, ret_a, exp_ret);
            end
        end
        exp_ret++;
    endtask

    task automatic test_sw();
        logic [18:0] ev [4] = '{V_FETCH_R, V_DECODE, V_MADDR, V_MEMWR};
        op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            cycle_in(1'b0, 1'b1);
            n_chk++;
            if (ctl_a !== ev[i]) begin
                n_fail++;
                $display("FAIL sw_ctl cycle %0d: got %b expected %b", i, ctl_a, ev[i]);
            end
            if (i == 0) begin
                n_chk++;
                if (ret_a !== 32'(exp_ret)) begin
                    n_fail++;
                    $display("FAIL sw_retired_start: got %0d expected %0d", ret_a, exp_ret);
                end
            end
        end
        exp_ret++;
    endtask

    task automatic test_branch();
        logic [5:0]  ops [2] = '{6'b000100, 6'b000101};
        logic [18:0] ex  [2] = '{V_BEQ, V_BNE};
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            for (int i = 0; i < 3; i++) begin
                cycle_in(1'b0, 1'b1);
                n_chk++;
                if (ctl_a !== ((i == 0) ? V_FETCH_R : (i == 1) ? V_DECODE : ex[k])) begin
                    n_fail++;
                    $display("FAIL branch%0d_ctl cycle %0d: got %b", k, i, ctl_a);
                end
            end
            exp_ret++;
        end
        cycle_in(1'b0, 1'b1);
        n_chk++;
        if (ctl_a !== V_FETCH_R || ret_a !== 32'(exp_ret)) begin
            n_fail++;
            $display("FAIL branch_retired: ctl %b retired %0d expected %0d", ctl_a, ret_a, exp_ret);
        end
        exp_ret++;
        // that FETCH began a j (op stays bne? no: switch now, stable from DECODE)
        op = 6'b000010;
        cycle_in(1'b0, 1'b1);
        cycle_in(1'b0, 1'b1);
        n_chk++;
        if (ctl_a !== V_JUMP) begin
            n_fail++;
            $display("FAIL jump_ctl: got %b expected %b", ctl_a, V_JUMP);
        end
    endtask

    task automatic test_alu();
        logic [5:0]  ops  [3] = '{6'b001100, 6'b001000, 6'b000000};
        logic [18:0] exec [3] = '{V_EXEC_ANDI, V_EXEC_ADDI, V_EXEC_R};
        logic [18:0] wb   [3] = '{V_WB_I, V_WB_I, V_WB_R};
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            cycle_in(1'b0, 1'b1);
            n_chk++;
            if (ctl_a !== V_FETCH_R || ret_a !== 32'(exp_ret)) begin
                n_fail++;
                $display("FAIL alu%0d_fetch: ctl %b retired %0d expected %0d", k, ctl_a, ret_a, exp_ret);
            end
            cycle_in(1'b0, 1'b1);
            cycle_in(1'b0, 1'b1);
            n_chk++;
            if (ctl_a !== exec[k]) begin
                n_fail++;
                $display("FAIL alu%0d_exec: got %b expected %b", k, ctl_a, exec[k]);
            end
            cycle_in(1'b0, 1'b1);
            n_chk++;
            if (ctl_a !== wb[k]) begin
                n_fail++;
                $display("FAIL alu%0d_wb: got %b expected %b", k, ctl_a, wb[k]);
            end
            exp_ret++;
        end
    endtask

    task automatic test_illegal();
        op = 6'b111111;
        cycle_in(1'b0, 1'b1);
        n_chk++;
        if (ret_a !== 32'(exp_ret) || ret_b !== exp_ret[1:0]) begin
            n_fail++;
            $display("FAIL illegal_start_retired: a=%0d b=%0d expected %0d", ret_a, ret_b, exp_ret);
        end
        cycle_in(1'b0, 1'b1);
        cycle_in(1'b0, 1'b1);
        n_chk++;
        if (ctl_a !== V_ZERO || ctl_b !== V_ZERO || ill_b !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_enter: a %b b %b ill_b %b expected all 0", ctl_a, ctl_b, ill_b);
        end
        for (int i = 0; i < 20; i++) begin
            cycle_in(1'b0, 1'b1);
            n_chk++;
            if (ctl_a !== V_ZERO || ill_a !== 1'b1 || ret_a !== 32'(exp_ret)) begin
                n_fail++;
                $display("FAIL illegal_hold cycle %0d: ctl %b ill %b retired %0d", i, ctl_a, ill_a, ret_a);
            end
            if (i == 0) begin
                n_chk++;
                if (ctl_b !== V_FETCH_R || ret_b !== exp_ret[1:0] || ill_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL illegal_nop: b ctl %b retired %0d ill %b", ctl_b, ret_b, ill_b);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        cycle_in(1'b1, 1'b1);
        n_chk++;
        if (ctl_a !== V_ZERO) begin
            n_fail++;
            $display("FAIL trap_reset_ctl: got %b expected %b", ctl_a, V_ZERO);
        end
        exp_ret = 0;
        op = 6'b000010;
        for (int i = 0; i < 3; i++) cycle_in(1'b0, 1'b1);
        n_chk++;
        if (ctl_a !== V_JUMP || ill_a !== 1'b0) begin
            n_fail++;
            $display("FAIL post_trap_jump: ctl %b ill %b", ctl_a, ill_a);
        end
        op = 6'b101011;
        cycle_in(1'b0, 1'b1);
        n_chk++;
        if (ret_a !== 32'd1) begin
            n_fail++;
            $display("FAIL pre_abort_retired: got %0d expected 1", ret_a);
        end
        cycle_in(1'b0, 1'b1);
        cycle_in(1'b0, 1'b0);
        cycle_in(1'b0, 1'b0);
        n_chk++;
        if (ctl_a !== V_MEMWR) begin
            n_fail++;
            $display("FAIL memwr_wait: got %b expected %b", ctl_a, V_MEMWR);
        end
        cycle_in(1'b1, 1'b0);
        n_chk++;
        if (ctl_a !== V_MEMWR_RST) begin
            n_fail++;
            $display("FAIL memwr_reset_ctl: got %b expected %b", ctl_a, V_MEMWR_RST);
        end
        cycle_in(1'b0, 1'b1);
        n_chk++;
        if (ctl_a !== V_FETCH_R || ret_a !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_fetch: ctl %b retired %0d expected %b / 0", ctl_a, ret_a, V_FETCH_R);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_alu();
        test_illegal();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
